// File: rtl/uart_pwm_pkg.sv
// Shared constants and state encoding for the UART-to-servo command path.
// Frame: START, W[23:16], W[15:8], W[7:0], END; reply is ACK or NAK.
package uart_pwm_pkg;

    localparam logic [7:0] FRAME_START = 8'h42;
    localparam logic [7:0] FRAME_END   = 8'h0A;
    localparam logic [7:0] RESP_ACK    = 8'h4B;
    localparam logic [7:0] RESP_NAK    = 8'h45;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HI   = 3'd1,
        ST_MID  = 3'd2,
        ST_LO   = 3'd3,
        ST_TERM = 3'd4,
        ST_RESP = 3'd5
    } state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/frame_timer.sv
// Inter-byte gap counter: held at zero while disabled or cleared, otherwise
// counts up and flags expiry once TIMEOUT_CYCLES idle cycles have elapsed.
module frame_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 270000
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Expiry fires in the cycle the count would reach TIMEOUT_CYCLES.
    assign expired_o = enable_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || !enable_i) begin
            cnt_d = '0;
        end else if (!expired_o) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_servo_cmd.sv
// Parses 5-byte servo frames from the UART receiver, range-checks the width,
// updates the servo pulse width and answers ACK/NAK via the UART transmitter.
module uart_servo_cmd
    import uart_pwm_pkg::*;
#(
    parameter logic [23:0] DEFAULT_WIDTH  = 24'd54054,
    parameter logic [23:0] MIN_WIDTH      = 24'd13500,
    parameter logic [23:0] MAX_WIDTH      = 24'd67500,
    parameter int unsigned TIMEOUT_CYCLES = 270000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        tx_busy,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic [23:0] pwm_width,
    output logic        pwm_update,
    output logic [7:0]  err_count
);

    state_e      state_q,  state_d;
    logic [23:0] shadow_q, shadow_d;
    logic [23:0] width_q,  width_d;
    logic        update_q, update_d;
    logic [7:0]  err_q,    err_d;
    logic [7:0]  txd_q,    txd_d;
    logic        txv_q,    txv_d;

    logic in_frame;
    logic timer_expired;
    logic frame_good;

    assign in_frame = (state_q == ST_HI) || (state_q == ST_MID) ||
                      (state_q == ST_LO) || (state_q == ST_TERM);

    frame_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_frame_timer (
        .clk       (clk),
        .resetn    (resetn),
        .clear_i   (rx_valid),
        .enable_i  (in_frame),
        .expired_o (timer_expired)
    );

    assign frame_good = (rx_data == FRAME_END) &&
                        (shadow_q >= MIN_WIDTH) && (shadow_q <= MAX_WIDTH);

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        width_d  = width_q;
        update_d = 1'b0;
        err_d    = err_q;
        txd_d    = txd_q;
        txv_d    = txv_q;

        unique case (state_q)
            ST_IDLE: begin
                if (rx_valid && (rx_data == FRAME_START)) begin
                    state_d = ST_HI;
                end
            end
            ST_HI, ST_MID, ST_LO: begin
                // A received byte always wins over a coincident timeout.
                if (rx_valid) begin
                    shadow_d = {shadow_q[15:0], rx_data};
                    state_d  = (state_q == ST_HI)  ? ST_MID :
                               (state_q == ST_MID) ? ST_LO  : ST_TERM;
                end else if (timer_expired) begin
                    state_d = ST_IDLE;
                    err_d   = sat_inc8(err_q);
                end
            end
            ST_TERM: begin
                if (rx_valid) begin
                    if (frame_good) begin
                        width_d  = shadow_q;
                        update_d = 1'b1;
                        txd_d    = RESP_ACK;
                    end else begin
                        err_d = sat_inc8(err_q);
                        txd_d = RESP_NAK;
                    end
                    txv_d   = 1'b1;
                    state_d = ST_RESP;
                end else if (timer_expired) begin
                    state_d = ST_IDLE;
                    err_d   = sat_inc8(err_q);
                end
            end
            ST_RESP: begin
                if (!tx_busy) begin
                    txv_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                txv_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            shadow_q <= '0;
            width_q  <= DEFAULT_WIDTH;
            update_q <= 1'b0;
            err_q    <= '0;
            txd_q    <= '0;
            txv_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            width_q  <= width_d;
            update_q <= update_d;
            err_q    <= err_d;
            txd_q    <= txd_d;
            txv_q    <= txv_d;
        end
    end

    assign tx_data    = txd_q;
    assign tx_valid   = txv_q;
    assign pwm_width  = width_q;
    assign pwm_update = update_q;
    assign err_count  = err_q;

endmodule

// File: tb/tb_uart_servo_cmd.sv
// Randomized self-checking bench for uart_servo_cmd against a frame-level
// model (accept/reject per frame, width register, saturating error count).
module tb_uart_servo_cmd;

    localparam int          T    = 200;
    localparam logic [23:0] DEFW = 24'd54054;
    localparam logic [23:0] MINW = 24'd13500;
    localparam logic [23:0] MAXW = 24'd67500;

    logic        clk = 1'b0;
    logic        resetn;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        tx_busy;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic [23:0] pwm_width;
    logic        pwm_update;
    logic [7:0]  err_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [23:0] exp_pwm;
    logic [7:0]  exp_err;

    uart_servo_cmd #(
        .DEFAULT_WIDTH (DEFW),
        .MIN_WIDTH     (MINW),
        .MAX_WIDTH     (MAXW),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_busy   (tx_busy),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .pwm_width (pwm_width),
        .pwm_update(pwm_update),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at a negedge; returns at the negedge after the byte was sampled.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Sends one complete frame and checks outputs through the response.
    task automatic run_frame(input logic [23:0] w, input logic [7:0] term,
                             input int gap, input int busy, input bit strays);
        logic [7:0] bytes [5];
        logic [7:0] resp;
        bit         good;
        bit         changed;
        bytes[0] = 8'h42;
        bytes[1] = w[23:16];
        bytes[2] = w[15:8];
        bytes[3] = w[7:0];
        bytes[4] = term;
        good    = (term == 8'h0A) && (w >= MINW) && (w <= MAXW);
        changed = good && (w != exp_pwm);
        if (good) begin
            exp_pwm = w;
            resp    = 8'h4B;
        end else begin
            exp_err = (exp_err == 8'hFF) ? 8'hFF : exp_err + 8'd1;
            resp    = 8'h45;
        end
        tx_busy = (busy > 0);
        for (int i = 0; i < 5; i++) begin
            send_byte(bytes[i]);
            if (i < 4) repeat (gap) @(negedge clk);
        end
        n_tests += 4;
        if (pwm_width !== exp_pwm) begin
            n_fail++; $display("FAIL frame_pwm_width got %0d exp %0d", pwm_width, exp_pwm);
        end
        if (err_count !== exp_err) begin
            n_fail++; $display("FAIL frame_err_count got %0d exp %0d", err_count, exp_err);
        end
        if (tx_valid !== 1'b1) begin
            n_fail++; $display("FAIL frame_tx_valid got %b exp 1", tx_valid);
        end
        if (tx_data !== resp) begin
            n_fail++; $display("FAIL frame_tx_data got %h exp %h", tx_data, resp);
        end
        if (changed || !good) begin
            n_tests++;
            if (pwm_update !== changed) begin
                n_fail++; $display("FAIL frame_pwm_update got %b exp %b", pwm_update, changed);
            end
        end
        for (int k = 0; k < busy; k++) begin
            if (strays && ($urandom_range(1, 0) == 1)) begin
                rx_data  = ($urandom_range(2, 0) == 0) ? 8'h42 : 8'($urandom);
                rx_valid = 1'b1;
            end
            @(negedge clk);
            rx_valid = 1'b0;
            n_tests++;
            if (tx_valid !== 1'b1 || tx_data !== resp || pwm_update !== 1'b0) begin
                n_fail++;
                $display("FAIL busy_hold cycle %0d got valid=%b data=%h upd=%b exp valid=1 data=%h upd=0",
                         k, tx_valid, tx_data, pwm_update, resp);
            end
        end
        tx_busy = 1'b0;
        @(negedge clk);
        n_tests++;
        if (tx_valid !== 1'b0 || pwm_update !== 1'b0 || pwm_width !== exp_pwm) begin
            n_fail++;
            $display("FAIL resp_done got valid=%b upd=%b pwm=%0d exp valid=0 upd=0 pwm=%0d",
                     tx_valid, pwm_update, pwm_width, exp_pwm);
        end
        $display("[TB] frame 42 %h %h %h %h busy=%0d -> resp %h pwm %0d err %0d",
                 bytes[1], bytes[2], bytes[3], term, busy, resp, exp_pwm, exp_err);
    endtask

    task automatic test_reset();
        resetn   = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_busy  = 1'b0;
        exp_pwm  = DEFW;
        exp_err  = 8'd0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (tx_data !== 8'h00 || tx_valid !== 1'b0 || pwm_width !== DEFW ||
            pwm_update !== 1'b0 || err_count !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_values got data=%h valid=%b pwm=%0d upd=%b err=%0d",
                     tx_data, tx_valid, pwm_width, pwm_update, err_count);
        end
        resetn = 1'b1;
        @(negedge clk);
        $display("[TB] reset released");
    endtask

    task automatic test_directed();
        run_frame(24'd40500, 8'h0A, 0, 0, 0);
        run_frame(24'd16,    8'h0A, 0, 0, 0);
        run_frame(24'd40500, 8'h0B, 0, 0, 0);
        run_frame(24'h004242, 8'h0A, 1, 0, 0);
        run_frame(MINW,        8'h0A, 0, 0, 0);
        run_frame(MAXW,        8'h0A, 2, 0, 0);
        run_frame(MINW - 24'd1, 8'h0A, 0, 1, 0);
        run_frame(MAXW + 24'd1, 8'h0A, 0, 0, 0);
    endtask

    task automatic test_timeout();
        bit seen_tx = 1'b0;
        send_byte(8'h42);
        send_byte(8'h00);
        repeat (2 * T) begin
            @(negedge clk);
            if (tx_valid) seen_tx = 1'b1;
        end
        exp_err = (exp_err == 8'hFF) ? 8'hFF : exp_err + 8'd1;
        n_tests += 3;
        if (seen_tx) begin
            n_fail++; $display("FAIL timeout_no_resp got tx_valid=1 exp 0");
        end
        if (err_count !== exp_err) begin
            n_fail++; $display("FAIL timeout_err_count got %0d exp %0d", err_count, exp_err);
        end
        if (pwm_width !== exp_pwm) begin
            n_fail++; $display("FAIL timeout_pwm got %0d exp %0d", pwm_width, exp_pwm);
        end
        $display("[TB] timeout after 42 00 -> err %0d", exp_err);
        run_frame(24'd30000, 8'h0A, 0, 0, 0);
    endtask

    task automatic test_busy_hold();
        run_frame(24'd22222, 8'h0A, 0, 100, 1);
        run_frame(24'd60000, 8'h0A, 0, 0, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic [23:0] w;
            logic [7:0]  term;
            logic [7:0]  s;
            case ($urandom_range(3, 0))
                0: w = 24'($urandom_range(int'(MAXW), int'(MINW)));
                1: w = 24'($urandom_range(int'(MINW) - 1, 0));
                2: w = 24'($urandom_range(24'hFFFFFF, int'(MAXW) + 1));
                default: w = 24'($urandom);
            endcase
            term = 8'h0A;
            if ($urandom_range(4, 0) == 0) begin
                term = 8'($urandom);
                if (term == 8'h0A) term = 8'h0B;
            end
            repeat ($urandom_range(2, 0)) begin
                s = 8'($urandom);
                if (s == 8'h42) s = 8'h41;
                send_byte(s);
            end
            n_tests++;
            if (tx_valid !== 1'b0 || err_count !== exp_err) begin
                n_fail++;
                $display("FAIL idle_stray got valid=%b err=%0d exp valid=0 err=%0d",
                         tx_valid, err_count, exp_err);
            end
            run_frame(w, term, $urandom_range(5, 0), $urandom_range(4, 0), 1);
        end
    endtask

    task automatic test_err_saturate();
        for (int n = 0; n < 260; n++) begin
            run_frame(24'd5, 8'h0A, 0, 0, 0);
        end
    endtask

    task automatic test_reset_midframe();
        send_byte(8'h42);
        send_byte(8'h00);
        send_byte(8'h9E);
        send_byte(8'h34);
        resetn = 1'b0;
        exp_pwm = DEFW;
        exp_err = 8'd0;
        #1;
        n_tests++;
        if (pwm_width !== DEFW || tx_valid !== 1'b0 || err_count !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_midframe got pwm=%0d valid=%b err=%0d exp pwm=%0d valid=0 err=0",
                     pwm_width, tx_valid, err_count, DEFW);
        end
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        send_byte(8'h0A);
        repeat (4) @(negedge clk);
        n_tests++;
        if (tx_valid !== 1'b0 || pwm_width !== DEFW || err_count !== 8'd0) begin
            n_fail++;
            $display("FAIL term_after_reset got valid=%b pwm=%0d err=%0d exp valid=0 pwm=%0d err=0",
                     tx_valid, pwm_width, err_count, DEFW);
        end
        $display("[TB] reset after LO byte, terminator ignored");
        // Abandon a pending response by resetting while the transmitter is busy.
        tx_busy = 1'b1;
        send_byte(8'h42);
        send_byte(8'h00);
        send_byte(8'h9E);
        send_byte(8'h34);
        send_byte(8'h0A);
        repeat (3) @(negedge clk);
        n_tests++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h4B || pwm_width !== 24'd40500) begin
            n_fail++;
            $display("FAIL pending_resp got valid=%b data=%h pwm=%0d exp valid=1 data=4b pwm=40500",
                     tx_valid, tx_data, pwm_width);
        end
        resetn = 1'b0;
        #1;
        n_tests++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00 || pwm_width !== DEFW) begin
            n_fail++;
            $display("FAIL reset_resp got valid=%b data=%h pwm=%0d exp valid=0 data=00 pwm=%0d",
                     tx_valid, tx_data, pwm_width, DEFW);
        end
        @(negedge clk);
        resetn  = 1'b1;
        tx_busy = 1'b0;
        @(negedge clk);
        $display("[TB] reset during pending response");
        run_frame(24'd50000, 8'h0A, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_timeout();
        test_busy_hold();
        test_random();
        test_err_saturate();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
